wdb_entry_alloc: RTL and testbench

Write-data-buffer (WDB) entry allocator feeding the write request crossbar. It owns the free/busy state of every WDB entry and offers one free entry index per output channel (4 channels) on a valid/ready handshake. It reclaims entries when the downstream WDB read side reports them drained. It sits between the write request crossbar (alloc consumer) and the WDB/read-out logic (release producer).

---
 rtl/wdb_entry_alloc.sv | 97 +++++++++
 tb/tb_wdb_entry_alloc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wdb_entry_alloc.sv
// WDB entry allocator: per-channel free-entry offer (idx[1:0] selects the partition), multi-port release, sticky double-free flag.
// Offer is combinational from free_map; alloc/release take effect at the next edge; free_cnt is registered; alloc_vld never looks at alloc_rdy.
package vector_cache_pkg;
    localparam int DB_ENTRY_IDX_WIDTH = 6;
endpackage

module wdb_entry_alloc #(
    parameter  int DB_DEPTH = 64,
    localparam int CH_NUM   = 4,
    localparam int IW       = vector_cache_pkg::DB_ENTRY_IDX_WIDTH,
    localparam int CW       = $clog2(DB_DEPTH / 4) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [CH_NUM-1:0]           alloc_vld,
    output logic [CH_NUM-1:0][IW-1:0]   alloc_idx,
    input  logic [CH_NUM-1:0]           alloc_rdy,
    input  logic [CH_NUM-1:0]           rel_vld,
    input  logic [CH_NUM-1:0][IW-1:0]   rel_idx,
    output logic [CH_NUM-1:0][CW-1:0]   free_cnt,
    output logic                        all_free,
    output logic                        rel_err
);

    localparam int PD = DB_DEPTH / CH_NUM;

    if (DB_DEPTH != (1 << IW) || DB_DEPTH < 8) begin : g_depth_check
        $error("wdb_entry_alloc: DB_DEPTH must be 2**DB_ENTRY_IDX_WIDTH and at least 8");
    end

    logic [DB_DEPTH-1:0]          free_map;
    logic [DB_DEPTH-1:0]          map_nxt;
    logic [DB_DEPTH-1:0]          rel_set;
    logic [CH_NUM-1:0]            has_free;
    logic [CH_NUM-1:0][IW-1:0]    low_idx;
    logic [CH_NUM-1:0][CW-1:0]    cnt_nxt;
    logic                         err_nxt;

    // Lowest free entry per partition; scanning downwards lets the lowest hit be the last write.
    always_comb begin
        has_free = '0;
        low_idx  = '0;
        for (int p = 0; p < CH_NUM; p++) begin
            for (int j = PD - 1; j >= 0; j--) begin
                if (free_map[j*CH_NUM + p]) begin
                    has_free[p] = 1'b1;
                    low_idx[p]  = IW'(j*CH_NUM + p);
                end
            end
        end
    end

    assign alloc_vld = rst_n ? has_free : '0;
    assign alloc_idx = rst_n ? low_idx  : '0;
    assign all_free  = &free_map;

    always_comb begin
        rel_set = '0;
        err_nxt = rel_err;
        for (int k = 0; k < CH_NUM; k++) begin
            if (rel_vld[k]) begin
                rel_set[rel_idx[k]] = 1'b1;
                if (free_map[rel_idx[k]]) begin
                    err_nxt = 1'b1;
                end
            end
        end
        // Allocation is applied after release so a bogus release of the offered entry loses.
        map_nxt = free_map | rel_set;
        for (int p = 0; p < CH_NUM; p++) begin
            if (alloc_vld[p] && alloc_rdy[p]) begin
                map_nxt[low_idx[p]] = 1'b0;
            end
        end
        for (int p = 0; p < CH_NUM; p++) begin
            cnt_nxt[p] = '0;
            for (int j = 0; j < PD; j++) begin
                cnt_nxt[p] = cnt_nxt[p] + CW'(map_nxt[j*CH_NUM + p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_map <= '1;
            rel_err  <= 1'b0;
            for (int p = 0; p < CH_NUM; p++) begin
                free_cnt[p] <= CW'(PD);
            end
        end else begin
            free_map <= map_nxt;
            rel_err  <= err_nxt;
            free_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wdb_entry_alloc.sv
// Bench for wdb_entry_alloc: directed scenarios then random traffic, scored against an array-based free-list model.
module tb_wdb_entry_alloc;
    localparam int DEPTH = 64;
    localparam int IW    = 6;
    localparam int CW    = 5;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [3:0]               alloc_vld;
    logic [3:0][IW-1:0]       alloc_idx;
    logic [3:0]               alloc_rdy;
    logic [3:0]               rel_vld;
    logic [3:0][IW-1:0]       rel_idx;
    logic [3:0][CW-1:0]       free_cnt;
    logic                     all_free;
    logic                     rel_err;

    always #5 clk = ~clk;

    wdb_entry_alloc #(.DB_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .free_cnt  (free_cnt),
        .all_free  (all_free),
        .rel_err   (rel_err)
    );

    typedef struct {
        logic [3:0]          vld;
        logic [3:0][IW-1:0]  idx;
        logic [3:0][CW-1:0]  cnt;
        logic                af;
        logic                err;
    } exp_t;

    exp_t exp_q[$];
    bit   mfree[DEPTH];
    bit   merr;
    bit   issued[DEPTH];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest(input int p);
        for (int i = p; i < DEPTH; i += 4)
            if (mfree[i]) return i;
        return -1;
    endfunction

    function automatic int count(input int p);
        int c = 0;
        for (int i = p; i < DEPTH; i += 4)
            if (mfree[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mfree[i] = 1'b1;
        merr = 1'b0;
    endtask

    // One clock: publish the expected outputs for this cycle, drive inputs, advance the model.
    task automatic cycle(input bit r, input logic [3:0] rdy, input logic [3:0] rv,
                         input logic [3:0][IW-1:0] ri);
        exp_t e;
        int   lo[4];
        bit   nf[DEPTH];
        bit   af;
        @(posedge clk);
        #1;
        rst_n = r;
        af = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (!mfree[i]) af = 1'b0;
        for (int p = 0; p < 4; p++) begin
            lo[p]    = lowest(p);
            e.vld[p] = r && (lo[p] >= 0);
            e.idx[p] = e.vld[p] ? IW'(lo[p]) : '0;
            e.cnt[p] = CW'(count(p));
        end
        e.af  = af;
        e.err = merr;
        exp_q.push_back(e);
        alloc_rdy = rdy;
        rel_vld   = rv;
        rel_idx   = ri;
        if (!r) begin
            model_reset();
        end else begin
            nf = mfree;
            for (int k = 0; k < 4; k++) begin
                if (rv[k]) begin
                    if (mfree[ri[k]]) merr = 1'b1;
                    nf[ri[k]] = 1'b1;
                end
            end
            for (int p = 0; p < 4; p++)
                if (rdy[p] && lo[p] >= 0) nf[lo[p]] = 1'b0;
            mfree = nf;
        end
    endtask

    // Monitor: compares each cycle's outputs and tracks handed-out entries independently of the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alloc_vld", 64'(alloc_vld), 64'(e.vld));
                for (int p = 0; p < 4; p++)
                    if (e.vld[p]) chk($sformatf("alloc_idx%0d", p), 64'(alloc_idx[p]), 64'(e.idx[p]));
                chk("free_cnt", 64'(free_cnt), 64'(e.cnt));
                chk("all_free", 64'(all_free), 64'(e.af));
                chk("rel_err", 64'(rel_err), 64'(e.err));
            end
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < DEPTH; i++) issued[i] = 1'b0;
            end else begin
                for (int p = 0; p < 4; p++)
                    if (alloc_vld[p] && alloc_rdy[p])
                        chk("reissue", 64'(issued[alloc_idx[p]]), 64'(0));
                for (int k = 0; k < 4; k++)
                    if (rel_vld[k]) issued[rel_idx[k]] = 1'b0;
                for (int p = 0; p < 4; p++)
                    if (alloc_vld[p] && alloc_rdy[p]) issued[alloc_idx[p]] = 1'b1;
            end
        end
    end

    initial begin
        logic [3:0][IW-1:0] ri;
        logic [3:0]         rv;
        int                 idx;
        rst_n     = 1'b0;
        alloc_rdy = '0;
        rel_vld   = '0;
        rel_idx   = '0;
        model_reset();
        ri = '0;

        cycle(1'b0, 4'h0, 4'h0, ri);
        // Drain every partition, one index per channel per cycle, then one empty cycle.
        for (int i = 0; i < 17; i++) cycle(1'b1, 4'hF, 4'h0, ri);
        // Single release into exhausted partition 1 via port 2.
        ri[2] = IW'(21);
        cycle(1'b1, 4'h0, 4'b0100, ri);
        ri = '0;
        cycle(1'b1, 4'b0010, 4'h0, ri);
        // Four releases into partition 1 in one cycle, then reallocate them in order.
        ri[0] = IW'(5); ri[1] = IW'(9); ri[2] = IW'(13); ri[3] = IW'(1);
        cycle(1'b1, 4'h0, 4'hF, ri);
        ri = '0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0010, 4'h0, ri);
        // Entry 6: legal release, then a double free that must latch rel_err.
        ri[0] = IW'(6);
        cycle(1'b1, 4'h0, 4'b0001, ri);
        cycle(1'b1, 4'h0, 4'b0001, ri);
        // Release aimed at the currently offered entry while it is allocated.
        ri[0] = IW'(6);
        cycle(1'b1, 4'b0100, 4'b0001, ri);
        ri = '0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 4'h0, ri);
        // Mid-stream reset with busy entries.
        cycle(1'b0, 4'hF, 4'h0, ri);
        cycle(1'b1, 4'h0, 4'h0, ri);
        cycle(1'b1, 4'h0, 4'h0, ri);

        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 4; k++) begin
                idx   = $urandom_range(0, DEPTH - 1);
                ri[k] = IW'(idx);
                rv[k] = mfree[idx] ? ($urandom_range(0, 63) == 0) : $urandom_range(0, 1) == 1;
            end
            cycle(($urandom_range(0, 999) != 0), 4'($urandom), rv, ri);
        end
        ri = '0;
        cycle(1'b1, 4'h0, 4'h0, ri);
        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
